// File: rtl/frame_tx_scheduler.sv
// frame_tx_scheduler: raster-walks the frame buffer (optionally decimated) and hands pixels to the sender.
module frame_tx_scheduler #(
  parameter int IMG_W  = 320,
  parameter int IMG_H  = 240,
  parameter int ADDR_W = 17,
  parameter int PIX_W  = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        decim_shift,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [PIX_W-1:0]  rd_data,
  output logic [PIX_W-1:0]  pixel_out,
  output logic              pixel_valid,
  input  logic              sender_ready,
  output logic              busy,
  output logic              frame_done,
  output logic [ADDR_W-1:0] pixel_count
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, SEND, DONE} state_t;
  localparam logic [ADDR_W:0]   W_EXT = (ADDR_W+1)'(IMG_W);
  localparam logic [ADDR_W:0]   H_EXT = (ADDR_W+1)'(IMG_H);
  localparam logic [ADDR_W-1:0] ROW   = ADDR_W'(IMG_W);
  state_t state, nxt;
  logic [1:0] k;
  logic [ADDR_W-1:0] x, y, row_base;
  logic [ADDR_W:0] x_nxt, y_nxt;
  logic hs, x_wrap, last, go;
  // one extra bit so x+step / y+step cannot wrap before the bound compare
  assign x_nxt       = {1'b0, x} + ((ADDR_W+1)'(1) << k);
  assign y_nxt       = {1'b0, y} + ((ADDR_W+1)'(1) << k);
  assign x_wrap      = x_nxt >= W_EXT;
  assign last        = x_wrap && (y_nxt >= H_EXT);
  assign hs          = (state == SEND) && sender_ready;
  assign go          = (state == IDLE) && start && !abort;
  assign rd_en       = state == FETCH;
  assign rd_addr     = rd_en ? row_base + x : '0;
  assign pixel_valid = state == SEND;
  assign busy        = state != IDLE;
  assign frame_done  = state == DONE;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? FETCH : IDLE;
      FETCH:   nxt = LATCH;
      LATCH:   nxt = SEND;
      SEND:    nxt = hs ? (last ? DONE : FETCH) : SEND;
      default: nxt = IDLE;
    endcase
    if (abort && state != IDLE) nxt = IDLE;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      k           <= '0;
      x           <= '0;
      y           <= '0;
      row_base    <= '0;
      pixel_out   <= '0;
      pixel_count <= '0;
    end else begin
      state <= nxt;
      if (go) begin
        k           <= decim_shift;
        x           <= '0;
        y           <= '0;
        row_base    <= '0;
        pixel_count <= '0;
      end
      if (state == LATCH) pixel_out <= rd_data;
      if (hs) pixel_count <= pixel_count + ADDR_W'(1);
      if (hs && !last && !abort) begin
        x <= x_wrap ? '0 : x_nxt[ADDR_W-1:0];
        if (x_wrap) begin
          y        <= y_nxt[ADDR_W-1:0];
          row_base <= row_base + (ROW << k);
        end
      end
    end
  end
endmodule

// File: tb/tb_frame_tx_scheduler.sv
// tb_frame_tx_scheduler: randomized and directed checks of frame_tx_scheduler on a 4x3 frame.
module tb_frame_tx_scheduler;
  localparam int W = 4, H = 3, AW = 17, PW = 12;
  logic clk = 0, rst = 0, start = 0, abort = 0, sender_ready = 0;
  logic [1:0] decim_shift = 0;
  logic [AW-1:0] rd_addr, pixel_count;
  logic [PW-1:0] rd_data = 0, pixel_out;
  logic rd_en, pixel_valid, busy, frame_done;
  logic [PW-1:0] ram [0:15];
  int checks = 0, failures = 0, cyc = 0, done_cnt = 0, done_t = 0, c0 = 0;
  logic [PW-1:0] hs_q[$];
  int hs_t[$], rd_q[$], rd_t[$], exp_addr[$];

  always #5 clk = ~clk;

  frame_tx_scheduler #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .PIX_W(PW)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .decim_shift(decim_shift),
    .rd_addr(rd_addr), .rd_en(rd_en), .rd_data(rd_data), .pixel_out(pixel_out),
    .pixel_valid(pixel_valid), .sender_ready(sender_ready), .busy(busy),
    .frame_done(frame_done), .pixel_count(pixel_count));

  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr[3:0]];

  always @(negedge clk) begin
    cyc++;
    if (pixel_valid && sender_ready) begin hs_q.push_back(pixel_out); hs_t.push_back(cyc); end
    if (rd_en) begin rd_q.push_back(int'(rd_addr)); rd_t.push_back(cyc); end
    if (frame_done) begin done_cnt++; done_t = cyc; end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task tick; @(posedge clk); #1; endtask
  task clear_mon; hs_q.delete(); hs_t.delete(); rd_q.delete(); rd_t.delete(); done_cnt = 0; endtask
  task fill_ram(input bit rnd);
    for (int i = 0; i < 16; i++) ram[i] = rnd ? PW'($urandom) : PW'(i);
  endtask
  task model(input int k);
    int s;
    s = 1 << k;
    exp_addr.delete();
    for (int yy = 0; yy < H; yy += s)
      for (int xx = 0; xx < W; xx += s) exp_addr.push_back(yy * W + xx);
  endtask
  task start_frame(input logic [1:0] k);
    decim_shift = k; start = 1; tick; start = 0; c0 = cyc;
  endtask
  task wait_done(input int budget, output bit ok);
    for (int i = 0; i < budget && done_cnt == 0; i++) tick;
    ok = done_cnt != 0;
  endtask
  task wait_hs(input int n, output bit ok);
    for (int i = 0; i < 200 && hs_q.size() < n; i++) tick;
    ok = hs_q.size() == n;
  endtask
  task wait_valid(output bit ok);
    for (int i = 0; i < 20 && !pixel_valid; i++) tick;
    ok = pixel_valid;
  endtask

  task test_reset;
    rst = 0; tick; tick;
    @(negedge clk);
    checks++;
    if ({rd_addr, rd_en, pixel_out, pixel_valid, busy, frame_done, pixel_count} !== '0) begin
      failures++;
      $display("FAIL reset_values: got addr=%0d en=%b pix=%0d val=%b busy=%b done=%b cnt=%0d, want all 0",
               rd_addr, rd_en, pixel_out, pixel_valid, busy, frame_done, pixel_count);
    end
    tick; rst = 1; clear_mon;
    repeat (6) tick;
    checks++;
    if (rd_q.size() != 0 || busy !== 0 || pixel_valid !== 0) begin
      failures++;
      $display("FAIL idle_quiet: reads=%0d busy=%b valid=%b, want 0 0 0", rd_q.size(), busy, pixel_valid);
    end
  endtask

  task test_full_frame;
    bit ok;
    int bad;
    fill_ram(0); model(0); clear_mon; sender_ready = 1;
    start_frame(0);
    wait_done(100, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL full_done_timeout: no frame_done within 100 cycles"); end
    checks++;
    if (hs_q.size() != 12) begin failures++; $display("FAIL full_count: got %0d pixels, want 12", hs_q.size()); end
    else begin
      bad = 0;
      for (int i = 0; i < 12; i++) if (hs_q[i] !== ram[exp_addr[i]]) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL full_order: %0d pixels out of order, want 0", bad); end
      bad = 0;
      for (int i = 1; i < 12; i++) if (hs_t[i] - hs_t[i-1] != 3) bad++;
      checks++;
      if (bad != 0) begin failures++; $display("FAIL full_rate: %0d gaps not 3 cycles, want 0", bad); end
      checks++;
      if (done_t != hs_t[11] + 1) begin
        failures++; $display("FAIL done_timing: done at %0d, want %0d", done_t, hs_t[11] + 1);
      end
      checks++;
      if (rd_t[0] != c0 + 1 || hs_t[0] != c0 + 3) begin
        failures++; $display("FAIL start_latency: rd at +%0d valid at +%0d, want +1 +3", rd_t[0] - c0, hs_t[0] - c0);
      end
    end
    checks++;
    if (done_cnt != 1 || pixel_count !== 12 || busy !== 0) begin
      failures++;
      $display("FAIL full_end: done_cnt=%0d cnt=%0d busy=%b, want 1 12 0", done_cnt, pixel_count, busy);
    end
  endtask

  task test_decim;
    bit ok;
    int bad;
    fill_ram(1); model(1); clear_mon; sender_ready = 1;
    start_frame(1);
    wait_done(100, ok);
    bad = (rd_q.size() != exp_addr.size() || hs_q.size() != exp_addr.size()) ? 1 : 0;
    if (bad == 0)
      for (int i = 0; i < exp_addr.size(); i++) if (rd_q[i] != exp_addr[i] || hs_q[i] !== ram[exp_addr[i]]) bad++;
    checks++;
    if (!ok || bad != 0) begin
      failures++; $display("FAIL decim_addrs: done=%b reads=%0d errors=%0d, want 1 4 0", ok, rd_q.size(), bad);
    end
    checks++;
    if (pixel_count !== 4) begin failures++; $display("FAIL decim_count: got %0d want 4", pixel_count); end
  endtask

  task test_backpressure;
    bit ok, ok2;
    int bad;
    fill_ram(0); model(0); clear_mon; sender_ready = 1;
    start_frame(0);
    wait_hs(5, ok);
    sender_ready = 0;
    wait_valid(ok2);
    checks++;
    if (!ok || !ok2) begin failures++; $display("FAIL bp_setup: reach5=%b valid=%b want 1 1", ok, ok2); end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (pixel_valid !== 1 || pixel_out !== 5 || rd_en !== 0) bad++;
      tick;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL bp_hold: %0d unstable cycles want 0", bad); end
    sender_ready = 1;
    @(negedge clk);
    tick;
    @(negedge clk);
    checks++;
    if (rd_en !== 1 || rd_addr !== 6) begin
      failures++; $display("FAIL bp_next_read: en=%b addr=%0d want 1 6", rd_en, rd_addr);
    end
    tick;
    wait_done(100, ok);
    bad = 0;
    if (hs_q.size() == 12) for (int i = 0; i < 12; i++) if (hs_q[i] !== PW'(i)) bad++;
    checks++;
    if (!ok || hs_q.size() != 12 || rd_q.size() != 12 || bad != 0 || rd_t[6] != hs_t[5] + 1) begin
      failures++;
      $display("FAIL bp_frame: done=%b pix=%0d reads=%0d errs=%0d want 1 12 12 0", ok, hs_q.size(), rd_q.size(), bad);
    end
  endtask

  task test_abort;
    bit ok, ok2;
    fill_ram(0); clear_mon; sender_ready = 1;
    start_frame(0);
    wait_hs(6, ok);
    sender_ready = 0;
    wait_valid(ok2);
    abort = 1; tick; abort = 0;
    @(negedge clk);
    checks++;
    if (!ok || !ok2 || busy !== 0 || pixel_valid !== 0 || rd_en !== 0 || pixel_count !== 6) begin
      failures++;
      $display("FAIL abort_state: busy=%b val=%b en=%b cnt=%0d want 0 0 0 6", busy, pixel_valid, rd_en, pixel_count);
    end
    tick;
    repeat (5) tick;
    checks++;
    if (done_cnt != 0 || rd_q.size() != 7 || pixel_count !== 6) begin
      failures++; $display("FAIL abort_quiet: done=%0d reads=%0d cnt=%0d want 0 7 6", done_cnt, rd_q.size(), pixel_count);
    end
    sender_ready = 1; clear_mon;
    start_frame(0);
    wait_done(100, ok);
    checks++;
    if (!ok || rd_q.size() == 0 || rd_q[0] != 0 || hs_q.size() != 12 || pixel_count !== 12) begin
      failures++; $display("FAIL abort_restart: done=%b pix=%0d cnt=%0d want 1 12 12", ok, hs_q.size(), pixel_count);
    end
  endtask

  task test_ignored_start;
    bit ok;
    fill_ram(0); clear_mon; sender_ready = 1;
    start_frame(0);
    repeat (7) tick;
    decim_shift = 1; start = 1; tick; start = 0;
    wait_done(100, ok);
    repeat (5) tick;
    checks++;
    if (!ok || hs_q.size() != 12 || done_cnt != 1 || pixel_count !== 12 || busy !== 0) begin
      failures++;
      $display("FAIL ignored_start: done=%0d pix=%0d cnt=%0d busy=%b want 1 12 12 0", done_cnt, hs_q.size(), pixel_count, busy);
    end
    start = 1; abort = 1; tick; start = 0; abort = 0;
    @(negedge clk);
    tick;
    repeat (4) tick;
    checks++;
    if (busy !== 0 || rd_q.size() != 12) begin
      failures++; $display("FAIL start_abort_idle: busy=%b reads=%0d want 0 12", busy, rd_q.size());
    end
  endtask

  task test_reset_mid;
    clear_mon; sender_ready = 1;
    start_frame(0);
    repeat (10) tick;
    rst = 0; tick;
    @(negedge clk);
    checks++;
    if ({rd_addr, rd_en, pixel_out, pixel_valid, busy, frame_done, pixel_count} !== '0) begin
      failures++;
      $display("FAIL reset_mid: busy=%b val=%b pix=%0d cnt=%0d want 0 0 0 0", busy, pixel_valid, pixel_out, pixel_count);
    end
    tick; rst = 1;
    repeat (20) tick;
    checks++;
    if (done_cnt != 0 || busy !== 0) begin
      failures++; $display("FAIL reset_mid_quiet: done=%0d busy=%b want 0 0", done_cnt, busy);
    end
  endtask

  task test_random;
    bit ok;
    int bad, k;
    for (int n = 0; n < 8; n++) begin
      k = $urandom % 4;
      fill_ram(1); model(k); clear_mon;
      start_frame(2'(k));
      ok = 0;
      for (int i = 0; i < 400 && done_cnt == 0; i++) begin
        sender_ready = ($urandom % 3) != 0;
        start = ($urandom % 8) == 0;
        decim_shift = 2'($urandom);
        tick;
      end
      start = 0; sender_ready = 1;
      ok = done_cnt == 1;
      bad = (hs_q.size() != exp_addr.size() || rd_q.size() != exp_addr.size()) ? 1 : 0;
      if (bad == 0)
        for (int i = 0; i < exp_addr.size(); i++) if (rd_q[i] != exp_addr[i] || hs_q[i] !== ram[exp_addr[i]]) bad++;
      checks++;
      if (!ok || bad != 0 || pixel_count !== AW'(exp_addr.size())) begin
        failures++;
        $display("FAIL random_frame k=%0d: done=%0d pix=%0d cnt=%0d errs=%0d want 1 %0d %0d 0",
                 k, done_cnt, hs_q.size(), pixel_count, bad, exp_addr.size(), exp_addr.size());
      end
      repeat (2) tick;
    end
  endtask

  initial begin
    test_reset;
    test_full_frame;
    test_decim;
    test_backpressure;
    test_abort;
    test_ignored_start;
    test_reset_mid;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
